// File: rtl/fft_out_scale_ctrl.sv
// Output sequencer for the 64-point FFT: reads result RAM in natural or bit-reversed order and
// feeds each word through the external scaler. Output is a credit-guarded FIFO with a valid/ready port.
module fft_out_scale_ctrl #(
  parameter int N_POINTS   = 64,
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic              Start,
  input  logic              Scale_En,
  input  logic              Bitrev_En,
  output logic              Rd_En,
  output logic [ADDR_W-1:0] Rd_Addr,
  input  logic [DATA_W-1:0] Rd_Data,
  output logic [DATA_W-1:0] Scl_A32,
  output logic              Swap,
  input  logic [DATA_W-1:0] Scl_R32,
  output logic [DATA_W-1:0] Out_Data,
  output logic [ADDR_W-1:0] Out_Index,
  output logic              Out_Last,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic              Busy,
  output logic              Done,
  output logic              Start_Ign
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CR_W  = $clog2(FIFO_DEPTH + RD_LAT + 1);
  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(N_POINTS - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic                swap_q, swap_d;
  logic                bitrev_q, bitrev_d;
  logic                done_q, done_d;
  logic [ADDR_W-1:0]   k_rd_q, k_rd_d;

  logic [RD_LAT-1:0]   pipe_vld_q, pipe_vld_d;
  logic [ADDR_W-1:0]   pipe_k_q [RD_LAT];
  logic [ADDR_W-1:0]   pipe_k_d [RD_LAT];

  logic [DATA_W-1:0]   fifo_dat_q [FIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_dat_d [FIFO_DEPTH];
  logic [ADDR_W-1:0]   fifo_idx_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]   fifo_idx_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last_q, fifo_last_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    fifo_cnt_q, fifo_cnt_d;

  logic [CR_W-1:0]     inflight;
  logic [CR_W-1:0]     credit_used;
  logic                ret_vld;
  logic [ADDR_W-1:0]   ret_k;
  logic                push;
  logic                pop;

  function automatic logic [ADDR_W-1:0] bitrev_f(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    for (int i = 0; i < ADDR_W; i++) r[i] = a[ADDR_W-1-i];
    return r;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CR_W'(pipe_vld_q[i]);
  end

  assign credit_used = CR_W'(fifo_cnt_q) + inflight;
  assign ret_vld     = pipe_vld_q[RD_LAT-1];
  assign ret_k       = pipe_k_q[RD_LAT-1];
  assign push        = ret_vld;
  assign Out_Valid   = (fifo_cnt_q != '0);
  assign pop         = Out_Valid & Out_Ready;

  always_comb begin
    state_d   = state_q;
    swap_d    = swap_q;
    bitrev_d  = bitrev_q;
    k_rd_d    = k_rd_q;
    done_d    = 1'b0;
    Rd_En     = 1'b0;
    Start_Ign = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d  = S_READ;
          swap_d   = Scale_En;
          bitrev_d = Bitrev_En;
          k_rd_d   = '0;
        end
      end
      S_READ: begin
        Start_Ign = Start;
        // Issue only while every word in flight still has a guaranteed FIFO slot.
        Rd_En = (credit_used < CR_W'(FIFO_DEPTH));
        if (Rd_En) begin
          k_rd_d = k_rd_q + ADDR_W'(1);
          if (k_rd_q == K_LAST) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        Start_Ign = Start;
        if ((inflight == '0) && (fifo_cnt_q == CNT_W'(1)) && pop) begin
          state_d  = S_IDLE;
          swap_d   = 1'b0;
          bitrev_d = 1'b0;
          done_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pipe_vld_d    = pipe_vld_q;
    pipe_k_d      = pipe_k_q;
    pipe_vld_d[0] = Rd_En;
    pipe_k_d[0]   = k_rd_q;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_k_d[i]   = pipe_k_q[i-1];
    end

    fifo_dat_d  = fifo_dat_q;
    fifo_idx_d  = fifo_idx_q;
    fifo_last_d = fifo_last_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (push) begin
      fifo_dat_d[wr_ptr_q]  = Scl_R32;
      fifo_idx_d[wr_ptr_q]  = ret_k;
      fifo_last_d[wr_ptr_q] = (ret_k == K_LAST);
      wr_ptr_d              = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state_q     <= S_IDLE;
      swap_q      <= 1'b0;
      bitrev_q    <= 1'b0;
      done_q      <= 1'b0;
      k_rd_q      <= '0;
      pipe_vld_q  <= '0;
      fifo_last_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_k_q[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_dat_q[i] <= '0;
        fifo_idx_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      swap_q      <= swap_d;
      bitrev_q    <= bitrev_d;
      done_q      <= done_d;
      k_rd_q      <= k_rd_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_k_q    <= pipe_k_d;
      fifo_dat_q  <= fifo_dat_d;
      fifo_idx_q  <= fifo_idx_d;
      fifo_last_q <= fifo_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
    end
  end

  assign Rd_Addr   = bitrev_q ? bitrev_f(k_rd_q) : k_rd_q;
  assign Scl_A32   = Rd_Data;
  assign Swap      = swap_q;
  assign Busy      = (state_q != S_IDLE);
  assign Done      = done_q;
  // Head fields read as zero when empty so an idle port shows all-zero outputs.
  assign Out_Data  = Out_Valid ? fifo_dat_q[rd_ptr_q] : '0;
  assign Out_Index = Out_Valid ? fifo_idx_q[rd_ptr_q] : '0;
  assign Out_Last  = Out_Valid ? fifo_last_q[rd_ptr_q] : 1'b0;

endmodule

// File: tb/tb_fft_out_scale_ctrl.sv
// Bench for fft_out_scale_ctrl: RAM and scaler models, table-driven frames, scoreboard on the output port.
module tb_fft_out_scale_ctrl;
  localparam int RD_LAT    = 1;
  localparam int FIRST_LAT = 2 + RD_LAT;
  localparam int DONE_LAT  = 3 + RD_LAT + 63;

  logic        Clock;
  logic        nReset, Start, Scale_En, Bitrev_En;
  logic        Rd_En, Swap, Out_Last, Out_Valid, Out_Ready, Busy, Done, Start_Ign;
  logic [5:0]  Rd_Addr, Out_Index;
  logic [31:0] Rd_Data, Scl_A32, Scl_R32, Out_Data;

  fft_out_scale_ctrl #(.N_POINTS(64), .ADDR_W(6), .DATA_W(32), .RD_LAT(RD_LAT), .FIFO_DEPTH(4)) dut (
    .Clock(Clock), .nReset(nReset), .Start(Start), .Scale_En(Scale_En), .Bitrev_En(Bitrev_En),
    .Rd_En(Rd_En), .Rd_Addr(Rd_Addr), .Rd_Data(Rd_Data), .Scl_A32(Scl_A32), .Swap(Swap),
    .Scl_R32(Scl_R32), .Out_Data(Out_Data), .Out_Index(Out_Index), .Out_Last(Out_Last),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Busy(Busy), .Done(Done), .Start_Ign(Start_Ign)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [5:0]  k;
    logic        l;
  } exp_t;

  typedef struct {
    int          pat;
    logic        scale;
    logic        brev;
    int          rmode;
    int          first_lat;
    int          done_lat;
    logic        spec;
    logic [5:0]  spec_addr;
    logic [31:0] spec_word;
    logic [31:0] spec_exp;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] ram [64];
  exp_t        sb [$];
  int          ready_mode = 0;
  logic        mon_en = 0;
  logic        exp_swap = 0, exp_brev = 0;
  int          rd_k = 0, occ = 0;
  logic        hold_prev = 0, last_xfer_prev = 0;
  logic [38:0] prev_head = '0;

  function automatic logic [15:0] sra6(input logic [15:0] x);
    logic signed [15:0] s;
    s = x;
    return s >>> 6;
  endfunction

  function automatic logic [5:0] brev6(input logic [5:0] a);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = a[5-i];
    return r;
  endfunction

  function automatic vec_t mk(input int pat, input logic scale, input logic brev, input int rmode,
                              input int dl, input logic spec, input logic [5:0] sa,
                              input logic [31:0] sw, input logic [31:0] se);
    vec_t v;
    v.pat = pat; v.scale = scale; v.brev = brev; v.rmode = rmode;
    v.first_lat = FIRST_LAT; v.done_lat = dl;
    v.spec = spec; v.spec_addr = sa; v.spec_word = sw; v.spec_exp = se;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // External scaler: per-component arithmetic shift right by 6 when Swap is set.
  assign Scl_R32 = Swap ? {sra6(Scl_A32[31:16]), sra6(Scl_A32[15:0])} : Scl_A32;

  initial begin
    Rd_Data = '0;
    forever begin
      @(posedge Clock);
      Rd_Data <= Rd_En ? ram[Rd_Addr] : '0;
    end
  end

  initial begin
    logic [3:0] rpat;
    int rc;
    rpat = 4'b1001;
    rc = 0;
    Out_Ready = 1'b1;
    forever begin
      @(posedge Clock);
      #1;
      case (ready_mode)
        1: begin Out_Ready = rpat[3 - (rc % 4)]; rc++; end
        2: Out_Ready = 1'($urandom_range(0, 1));
        default: Out_Ready = 1'b1;
      endcase
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      if (mon_en) begin
        if (Rd_En) begin
          check("rd_overissue", 32'(rd_k < 64), 32'd1);
          check("rd_addr", 32'(Rd_Addr), exp_brev ? 32'(brev6(6'(rd_k))) : 32'(rd_k));
          check("credit_full", 32'(occ < 4), 32'd1);
          rd_k++;
        end
        occ = occ + int'(Rd_En) - int'(Out_Valid && Out_Ready);
        check("swap", 32'(Swap), Busy ? 32'(exp_swap) : 32'd0);
        if (hold_prev)
          check("hold_stable", {Out_Valid, Out_Data[24:0], Out_Index, Out_Last} , {1'b1, prev_head[31:7], prev_head[6:0]});
        if (Out_Valid && Out_Ready) begin
          if (sb.size() == 0) begin
            check("extra_word", 32'(Out_Index), 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            check("out_data", Out_Data, e.d);
            check("out_index", 32'(Out_Index), 32'(e.k));
            check("out_last", 32'(Out_Last), 32'(e.l));
          end
        end
        if (Done) check("done_after_last", 32'(last_xfer_prev), 32'd1);
        hold_prev      = Out_Valid && !Out_Ready;
        prev_head      = {Out_Data, Out_Index, Out_Last};
        last_xfer_prev = Out_Valid && Out_Ready && Out_Last;
      end
    end
  end

  task automatic fill_ram(input vec_t v);
    for (int a = 0; a < 64; a++) begin
      case (v.pat)
        0: ram[a] = {16'(a * 64), 16'(-(a * 64))};
        1: ram[a] = 32'(a);
        default: ram[a] = $urandom;
      endcase
    end
    if (v.spec) ram[v.spec_addr] = v.spec_word;
  endtask

  task automatic arm(input vec_t v);
    logic [5:0] a;
    logic [31:0] w, d;
    for (int k = 0; k < 64; k++) begin
      a = v.brev ? brev6(6'(k)) : 6'(k);
      w = ram[a];
      d = v.scale ? {sra6(w[31:16]), sra6(w[15:0])} : w;
      if (v.spec && a == v.spec_addr) d = v.spec_exp;
      sb.push_back({d, 6'(k), k == 63});
    end
    exp_swap = v.scale;
    exp_brev = v.brev;
    rd_k     = 0;
  endtask

  task automatic start_frame(input logic now, input logic scale, input logic brev);
    if (!now) begin
      @(posedge Clock);
      #1;
    end
    Start = 1'b1; Scale_En = scale; Bitrev_En = brev;
    @(posedge Clock);
    #1;
    Start = 1'b0; Scale_En = ~scale; Bitrev_En = ~brev;
  endtask

  task automatic wait_done(input int first_lat, input int done_lat, input int ign_at, output logic got);
    logic seen_v;
    int dc;
    got = 1'b0; seen_v = 1'b0; dc = 0;
    for (int c = 1; c <= 1000; c++) begin
      @(negedge Clock);
      if (c == 1) check("busy_after_start", 32'(Busy), 32'd1);
      if (!seen_v && Out_Valid) begin
        seen_v = 1'b1;
        check("first_valid_lat", 32'(c), 32'(first_lat));
      end
      if (ign_at > 0 && c == ign_at) begin
        Start = 1'b1; Scale_En = ~exp_swap; Bitrev_En = ~exp_brev;
        #1;
        check("start_ign", 32'(Start_Ign), 32'd1);
      end
      if (ign_at > 0 && c == ign_at + 1) Start = 1'b0;
      if (Done) begin
        got = 1'b1; dc = c;
        break;
      end
    end
    if (!got) begin
      check("done_timeout", 32'd0, 32'd1);
      sb.delete();
    end else begin
      if (done_lat > 0) check("done_lat", 32'(dc), 32'(done_lat));
      check("busy_at_done", 32'(Busy), 32'd0);
      check("sb_empty", 32'(sb.size()), 32'd0);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic got;
    fill_ram(v);
    arm(v);
    ready_mode = v.rmode;
    start_frame(1'b0, v.scale, v.brev);
    wait_done(v.first_lat, v.done_lat, 0, got);
  endtask

  initial begin
    vec_t vecs [5];
    vec_t v;
    logic got, found;
    int nd;

    vecs[0] = mk(0, 1'b1, 1'b0, 0, DONE_LAT, 1'b0, 6'd0, 32'h0, 32'h0);
    vecs[1] = mk(1, 1'b0, 1'b1, 0, DONE_LAT, 1'b0, 6'd0, 32'h0, 32'h0);
    vecs[2] = mk(2, 1'b1, 1'b1, 1, 0, 1'b0, 6'd0, 32'h0, 32'h0);
    vecs[3] = mk(2, 1'b1, 1'b0, 0, DONE_LAT, 1'b1, 6'd5, 32'h8000_FFC1, 32'hFE00_FFFF);
    vecs[4] = mk(2, 1'b0, 1'b0, 2, 0, 1'b0, 6'd0, 32'h0, 32'h0);

    nReset = 1'b0; Start = 1'b0; Scale_En = 1'b0; Bitrev_En = 1'b0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_valid", 32'(Out_Valid), 32'd0);
    check("rst_rd_en", 32'(Rd_En), 32'd0);
    check("rst_swap", 32'(Swap), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    nReset = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Ignored Start mid-frame, then a Start landing on the Done cycle.
    v = mk(1, 1'b0, 1'b0, 0, DONE_LAT, 1'b0, 6'd0, 32'h0, 32'h0);
    fill_ram(v);
    arm(v);
    ready_mode = 0;
    start_frame(1'b0, 1'b0, 1'b0);
    wait_done(FIRST_LAT, DONE_LAT, 10, got);
    if (got) begin
      v = mk(1, 1'b1, 1'b1, 0, DONE_LAT, 1'b0, 6'd0, 32'h0, 32'h0);
      arm(v);
      start_frame(1'b1, 1'b1, 1'b1);
      wait_done(FIRST_LAT, DONE_LAT, 0, got);
    end

    // Reset while word 20 sits at the output.
    mon_en = 1'b0;
    fill_ram(vecs[0]);
    start_frame(1'b0, 1'b1, 1'b0);
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge Clock);
      if (Out_Valid && Out_Index == 6'd20) begin
        found = 1'b1;
        break;
      end
    end
    check("rst_word20_seen", 32'(found), 32'd1);
    nReset = 1'b0;
    @(negedge Clock);
    nReset = 1'b1;
    check("mid_rst_busy", 32'(Busy), 32'd0);
    check("mid_rst_valid", 32'(Out_Valid), 32'd0);
    check("mid_rst_data", Out_Data, 32'd0);
    check("mid_rst_index", 32'(Out_Index), 32'd0);
    check("mid_rst_last", 32'(Out_Last), 32'd0);
    check("mid_rst_rd", {31'd0, Rd_En}, 32'd0);
    check("mid_rst_addr", 32'(Rd_Addr), 32'd0);
    check("mid_rst_swap", 32'(Swap), 32'd0);
    check("mid_rst_done", 32'(Done), 32'd0);
    check("mid_rst_ign", 32'(Start_Ign), 32'd0);
    nd = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge Clock);
      if (Done) nd++;
    end
    check("no_done_after_rst", 32'(nd), 32'd0);
    sb.delete();
    occ = 0; hold_prev = 1'b0; last_xfer_prev = 1'b0;
    mon_en = 1'b1;
    run_vec(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
